// File: rtl/reorder_buffer_if.sv
// Bundles the issue, writeback, lookup and commit signals of the reorder buffer.
// master drives issue/writeback/queries; slave is the ROB itself.
interface reorder_buffer_if #(
   parameter int IDX_W  = 4,
   parameter int NUM_WB = 2
);
   logic                    rdy;
   logic                    full;
   logic [IDX_W:0]          count;
   logic [IDX_W-1:0]        alloc_idx;
   logic [IDX_W-1:0]        head_idx;

   logic                    issue_valid;
   logic [1:0]              issue_type;
   logic [4:0]              issue_rd;
   logic [31:0]             issue_pc;
   logic                    issue_pred_taken;
   logic                    issue_ready;
   logic [31:0]             issue_value;

   logic [NUM_WB-1:0]       wb_valid;
   logic [NUM_WB*IDX_W-1:0] wb_idx;
   logic [NUM_WB*32-1:0]    wb_value;
   logic [NUM_WB-1:0]       wb_taken;
   logic [NUM_WB*32-1:0]    wb_target;

   logic [IDX_W-1:0]        qry_idx1, qry_idx2;
   logic                    qry_ready1, qry_ready2;
   logic [31:0]             qry_value1, qry_value2;

   logic                    commit_valid;
   logic [IDX_W-1:0]        commit_idx;
   logic                    commit_reg_we;
   logic [4:0]              commit_rd;
   logic [31:0]             commit_value;
   logic                    commit_store;
   logic                    flush;
   logic [31:0]             flush_pc;

   modport master (
      output rdy, issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
             issue_ready, issue_value, wb_valid, wb_idx, wb_value, wb_taken, wb_target,
             qry_idx1, qry_idx2,
      input  full, count, alloc_idx, head_idx, qry_ready1, qry_ready2, qry_value1,
             qry_value2, commit_valid, commit_idx, commit_reg_we, commit_rd,
             commit_value, commit_store, flush, flush_pc
   );

   modport slave (
      input  rdy, issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
             issue_ready, issue_value, wb_valid, wb_idx, wb_value, wb_taken, wb_target,
             qry_idx1, qry_idx2,
      output full, count, alloc_idx, head_idx, qry_ready1, qry_ready2, qry_value1,
             qry_value2, commit_valid, commit_idx, commit_reg_we, commit_rd,
             commit_value, commit_store, flush, flush_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: program-order allocation, out-of-order writeback,
// single-cycle operand lookup with bypass, and branch-mispredict flush at the head.
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int NUM_WB = 2
) (
   input  logic             clk,
   input  logic             rst,
   reorder_buffer_if.slave  rob
);
   typedef enum logic [1:0] {
      ENT_REG    = 2'd0,
      ENT_STORE  = 2'd1,
      ENT_BRANCH = 2'd2
   } entry_type_e;

   logic [DEPTH-1:0] busy, ready, pred_taken, taken;
   entry_type_e      etype  [DEPTH];
   logic [4:0]       rd     [DEPTH];
   logic [31:0]      pc     [DEPTH];
   logic [31:0]      target [DEPTH];
   logic [31:0]      value  [DEPTH];

   logic [IDX_W-1:0] head, tail;
   logic [IDX_W:0]   count;
   logic             full, do_issue, commit_valid, mispredict;

   logic [NUM_WB-1:0] wb_hit;
   logic [IDX_W-1:0]  wb_slot [NUM_WB];
   logic [31:0]       wb_val  [NUM_WB];
   logic [31:0]       wb_tgt  [NUM_WB];

   logic [IDX_W-1:0]  q_idx [2];
   logic              q_rdy [2];
   logic [31:0]       q_val [2];

   // NOTE: combinational blocks use blocking '=' with every output defaulted first so no
   // latch is inferred; the clocked blocks below use only non-blocking '<='.
   always_comb begin
      full         = (count == (IDX_W+1)'(DEPTH));
      commit_valid = rob.rdy && busy[head] && ready[head];
      mispredict   = commit_valid && (etype[head] == ENT_BRANCH) &&
                     (taken[head] != pred_taken[head]);
      do_issue     = rob.rdy && rob.issue_valid && !full && !mispredict;
      wb_hit       = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         wb_slot[k] = rob.wb_idx[k*IDX_W +: IDX_W];
         wb_val[k]  = rob.wb_value[k*32 +: 32];
         wb_tgt[k]  = rob.wb_target[k*32 +: 32];
         wb_hit[k]  = rob.rdy && !mispredict && rob.wb_valid[k] &&
                      busy[rob.wb_idx[k*IDX_W +: IDX_W]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || mispredict) begin
         busy  <= '0;
         ready <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int k = 0; k < NUM_WB; k++)
            if (wb_hit[k]) ready[wb_slot[k]] <= 1'b1;
         if (commit_valid) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         if (do_issue) begin
            busy[tail]  <= 1'b1;
            ready[tail] <= rob.issue_ready;
            tail        <= tail + 1'b1;
         end
         count <= count + (IDX_W+1)'(do_issue) - (IDX_W+1)'(commit_valid);
      end
   end

   // NOTE: the payload arrays are deliberately not reset; busy/ready gate every use,
   // so clearing them would only add reset fan-out to a RAM-like structure.
   always_ff @(posedge clk) begin
      // Channels are visited in ascending order, so the higher channel's write lands last.
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_hit[k]) begin
            value[wb_slot[k]]  <= wb_val[k];
            taken[wb_slot[k]]  <= rob.wb_taken[k];
            target[wb_slot[k]] <= wb_tgt[k];
         end
      end
      if (do_issue) begin
         etype[tail]      <= entry_type_e'(rob.issue_type);
         rd[tail]         <= rob.issue_rd;
         pc[tail]         <= rob.issue_pc;
         pred_taken[tail] <= rob.issue_pred_taken;
         taken[tail]      <= rob.issue_pred_taken;
         target[tail]     <= '0;
         value[tail]      <= rob.issue_value;
      end
   end

   assign q_idx[0] = rob.qry_idx1;
   assign q_idx[1] = rob.qry_idx2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         q_rdy[p] = busy[q_idx[p]] && ready[q_idx[p]];
         q_val[p] = q_rdy[p] ? value[q_idx[p]] : '0;
         for (int k = 0; k < NUM_WB; k++) begin
            if (rob.wb_valid[k] && (wb_slot[k] == q_idx[p])) begin
               q_rdy[p] = 1'b1;
               q_val[p] = wb_val[k];
            end
         end
      end
   end

   assign rob.full          = full;
   assign rob.count         = count;
   assign rob.alloc_idx     = tail;
   assign rob.head_idx      = head;
   assign rob.qry_ready1    = q_rdy[0];
   assign rob.qry_value1    = q_val[0];
   assign rob.qry_ready2    = q_rdy[1];
   assign rob.qry_value2    = q_val[1];
   assign rob.commit_valid  = commit_valid;
   assign rob.commit_idx    = commit_valid ? head : '0;
   assign rob.commit_reg_we = commit_valid && (etype[head] == ENT_REG) && (rd[head] != '0);
   assign rob.commit_rd     = commit_valid ? rd[head] : '0;
   assign rob.commit_value  = commit_valid ? value[head] : '0;
   assign rob.commit_store  = commit_valid && (etype[head] == ENT_STORE);
   assign rob.flush         = mispredict;
   assign rob.flush_pc      = mispredict ? (taken[head] ? target[head] : pc[head] + 32'd4) : '0;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random phase,
// all compared against a queue-based model of the in-flight instructions.
module tb_reorder_buffer;
   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;
   localparam int NUM_WB = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reorder_buffer_if #(.IDX_W(IDX_W), .NUM_WB(NUM_WB)) rif ();
   reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
      .clk(clk), .rst(rst), .rob(rif)
   );

   typedef struct {
      int          idx;
      int          typ;
      logic [4:0]  rd;
      logic [31:0] pc;
      bit          pred;
      bit          rdy_v;
      logic [31:0] val;
      bit          tk;
      logic [31:0] tgt;
   } ent_t;

   ent_t q[$];
   int   base   = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0;
      rif.rdy = 1'b1;
      rif.issue_valid = 1'b0; rif.issue_type = '0; rif.issue_rd = '0; rif.issue_pc = '0;
      rif.issue_pred_taken = 1'b0; rif.issue_ready = 1'b0; rif.issue_value = '0;
      rif.wb_valid = '0; rif.wb_idx = '0; rif.wb_value = '0; rif.wb_taken = '0;
      rif.wb_target = '0; rif.qry_idx1 = '0; rif.qry_idx2 = '0;
   endtask

   task automatic set_issue(input int typ, input int rd, input logic [31:0] pc,
                            input bit pred, input bit rv, input logic [31:0] val);
      rif.issue_valid = 1'b1; rif.issue_type = 2'(typ); rif.issue_rd = 5'(rd);
      rif.issue_pc = pc; rif.issue_pred_taken = pred; rif.issue_ready = rv;
      rif.issue_value = val;
   endtask

   task automatic set_wb(input int k, input int idx, input logic [31:0] val,
                         input bit tk, input logic [31:0] tgt);
      rif.wb_valid[k] = 1'b1;
      rif.wb_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
      rif.wb_value[k*32 +: 32] = val;
      rif.wb_taken[k] = tk;
      rif.wb_target[k*32 +: 32] = tgt;
   endtask

   function automatic void exp_query(input int qi, output bit r, output logic [31:0] v);
      r = 1'b0; v = '0;
      foreach (q[i]) if (q[i].idx == qi && q[i].rdy_v) begin r = 1'b1; v = q[i].val; end
      for (int k = 0; k < NUM_WB; k++)
         if (rif.wb_valid[k] && int'(rif.wb_idx[k*IDX_W +: IDX_W]) == qi) begin
            r = 1'b1; v = rif.wb_value[k*32 +: 32];
         end
   endfunction

   task automatic compare_all();
      ent_t h; bit cv, fl, r1, r2; logic [31:0] v1, v2;
      h = '{default: 0};
      if (q.size() > 0) h = q[0];
      cv = rif.rdy && q.size() > 0 && h.rdy_v;
      fl = cv && h.typ == 2 && h.tk != h.pred;
      exp_query(int'(rif.qry_idx1), r1, v1);
      exp_query(int'(rif.qry_idx2), r2, v2);
      check("count", 32'(rif.count), 32'(q.size()));
      check("full", 32'(rif.full), 32'(q.size() == DEPTH));
      check("alloc_idx", 32'(rif.alloc_idx), 32'((base + q.size()) % DEPTH));
      check("head_idx", 32'(rif.head_idx), 32'(base));
      check("commit_valid", 32'(rif.commit_valid), 32'(cv));
      check("commit_idx", 32'(rif.commit_idx), cv ? 32'(base) : 32'd0);
      check("commit_reg_we", 32'(rif.commit_reg_we), 32'(cv && h.typ == 0 && h.rd != 0));
      check("commit_rd", 32'(rif.commit_rd), cv ? 32'(h.rd) : 32'd0);
      check("commit_value", rif.commit_value, cv ? h.val : 32'd0);
      check("commit_store", 32'(rif.commit_store), 32'(cv && h.typ == 1));
      check("flush", 32'(rif.flush), 32'(fl));
      check("flush_pc", rif.flush_pc, fl ? (h.tk ? h.tgt : h.pc + 32'd4) : 32'd0);
      check("qry_ready1", 32'(rif.qry_ready1), 32'(r1));
      check("qry_value1", rif.qry_value1, v1);
      check("qry_ready2", 32'(rif.qry_ready2), 32'(r2));
      check("qry_value2", rif.qry_value2, v2);
   endtask

   task automatic model_edge();
      bit cv, fl, full_pre; int alloc; ent_t e;
      if (rst) begin q.delete(); base = 0; return; end
      if (!rif.rdy) return;
      cv = q.size() > 0 && q[0].rdy_v;
      fl = cv && q[0].typ == 2 && q[0].tk != q[0].pred;
      if (fl) begin q.delete(); base = 0; return; end
      full_pre = (q.size() == DEPTH);
      alloc = (base + q.size()) % DEPTH;
      for (int k = 0; k < NUM_WB; k++)
         if (rif.wb_valid[k])
            foreach (q[i])
               if (q[i].idx == int'(rif.wb_idx[k*IDX_W +: IDX_W])) begin
                  q[i].rdy_v = 1'b1;
                  q[i].val   = rif.wb_value[k*32 +: 32];
                  q[i].tk    = rif.wb_taken[k];
                  q[i].tgt   = rif.wb_target[k*32 +: 32];
               end
      if (cv) begin void'(q.pop_front()); base = (base + 1) % DEPTH; end
      if (rif.issue_valid && !full_pre) begin
         e.idx = alloc; e.typ = int'(rif.issue_type); e.rd = rif.issue_rd;
         e.pc = rif.issue_pc; e.pred = rif.issue_pred_taken; e.rdy_v = rif.issue_ready;
         e.val = rif.issue_value; e.tk = rif.issue_pred_taken; e.tgt = '0;
         q.push_back(e);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic int next_idx();
      return (base + q.size()) % DEPTH;
   endfunction

   initial begin
      int br, a;
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      q.delete(); base = 0;
      rst = 1'b1; cycle();
      idle(); #1;
      check("reset_count", 32'(rif.count), 32'd0);
      check("reset_full", 32'(rif.full), 32'd0);
      check("reset_alloc", 32'(rif.alloc_idx), 32'd0);

      // Fill to DEPTH, then one refused issue.
      for (int i = 0; i < DEPTH; i++) begin
         idle(); set_issue(0, i + 1, 32'h1000 + 4 * i, 1'b0, 1'b0, '0); cycle();
      end
      idle(); #1;
      check("fill_full", 32'(rif.full), 32'd1);
      check("fill_count", 32'(rif.count), 32'd16);
      idle(); set_issue(0, 9, 32'h2000, 1'b0, 1'b1, 32'hDEAD); cycle();
      idle(); #1;
      check("overflow_alloc", 32'(rif.alloc_idx), 32'd0);
      check("overflow_count", 32'(rif.count), 32'd16);

      for (int i = DEPTH - 1; i >= 0; i--) begin
         idle(); set_wb(i % 2, i, 32'h5000 + i, 1'b0, '0); cycle();
      end
      for (int i = 0; i < DEPTH; i++) begin
         idle(); #1;
         check("drain_idx", 32'(rif.commit_idx), 32'(i));
         check("drain_rd", 32'(rif.commit_rd), 32'(i + 1));
         check("drain_value", rif.commit_value, 32'h5000 + i);
         cycle();
      end

      // Dual writeback collision on entry 3.
      for (int i = 0; i < 4; i++) begin
         idle(); set_issue(0, 5 + i, 32'h3000 + 4 * i, 1'b0, 1'b0, '0); cycle();
      end
      idle(); set_wb(0, 3, 32'hAAAA, 1'b0, '0); set_wb(1, 3, 32'hBBBB, 1'b0, '0);
      rif.qry_idx1 = 4'd3; #1;
      check("collide_bypass", rif.qry_value1, 32'hBBBB);
      cycle();
      idle(); rif.qry_idx1 = 4'd3; #1;
      check("collide_stored", rif.qry_value1, 32'hBBBB);
      check("collide_ready", 32'(rif.qry_ready1), 32'd1);
      cycle();
      idle(); set_wb(0, 0, 32'h10, 1'b0, '0); set_wb(1, 1, 32'h11, 1'b0, '0); cycle();
      idle(); set_wb(0, 2, 32'h12, 1'b0, '0); cycle();
      repeat (5) begin idle(); cycle(); end

      // Mispredict: taken branch predicted not-taken.
      br = next_idx();
      idle(); set_issue(2, 0, 32'h100, 1'b0, 1'b0, '0); cycle();
      for (int i = 0; i < 3; i++) begin
         idle(); set_issue(0, 10 + i, 32'h104 + 4 * i, 1'b0, 1'b1, 32'h77 + i); cycle();
      end
      idle(); set_wb(0, br, 32'h0, 1'b1, 32'h200); cycle();
      idle(); #1;
      check("flush_hi", 32'(rif.flush), 32'd1);
      check("flush_pc", rif.flush_pc, 32'h200);
      set_issue(0, 3, 32'h900, 1'b0, 1'b1, 32'h1); cycle();
      idle(); #1;
      check("flush_lo", 32'(rif.flush), 32'd0);
      check("post_flush_count", 32'(rif.count), 32'd0);
      check("post_flush_alloc", 32'(rif.alloc_idx), 32'd0);

      // Same setup, correctly predicted: branch retires without a flush.
      br = next_idx();
      idle(); set_issue(2, 0, 32'h100, 1'b0, 1'b0, '0); cycle();
      for (int i = 0; i < 3; i++) begin
         idle(); set_issue(0, 10 + i, 32'h104 + 4 * i, 1'b0, 1'b0, '0); cycle();
      end
      idle(); set_wb(0, br, 32'h0, 1'b0, 32'h200); cycle();
      idle(); #1;
      check("branch_commit", 32'(rif.commit_valid), 32'd1);
      check("branch_noflush", 32'(rif.flush), 32'd0);
      check("branch_reg_we", 32'(rif.commit_reg_we), 32'd0);
      cycle();
      idle(); set_wb(0, 1, 32'h21, 1'b0, '0); set_wb(1, 2, 32'h22, 1'b0, '0); cycle();
      idle(); set_wb(1, 3, 32'h23, 1'b0, '0); cycle();
      repeat (4) begin idle(); cycle(); end

      // Steady state of two entries while issuing and committing every cycle.
      a = next_idx();
      idle(); set_issue(0, 1, 32'h400, 1'b0, 1'b0, '0); cycle();
      idle(); set_issue(0, 0, 32'h404, 1'b0, 1'b1, 32'h44); cycle();
      idle(); set_wb(0, a, 32'h40, 1'b0, '0); cycle();
      for (int i = 0; i < 40; i++) begin
         idle();
         set_issue(0, int'($urandom_range(0, 3)), 32'h408 + 4 * i, 1'b0, 1'b1, $urandom);
         cycle();
         check("wrap_count", 32'(rif.count), 32'd2);
      end
      repeat (3) begin idle(); cycle(); end

      // rdy low freezes a ready STORE at the head.
      idle(); set_issue(1, 7, 32'h300, 1'b0, 1'b1, 32'h55); cycle();
      for (int i = 0; i < 5; i++) begin
         idle(); rif.rdy = 1'b0;
         set_issue(0, 4, 32'h310, 1'b0, 1'b1, 32'h66);
         set_wb(0, base, 32'h99, 1'b0, '0);
         cycle();
         check("rdy_frozen_count", 32'(rif.count), 32'd1);
      end
      idle(); #1;
      check("store_commit", 32'(rif.commit_store), 32'd1);
      check("store_reg_we", 32'(rif.commit_reg_we), 32'd0);
      check("store_value", rif.commit_value, 32'h55);
      cycle();

      // Random traffic, including occasional resets and stalls.
      for (int n = 0; n < 400; n++) begin
         int t;
         idle();
         rif.rdy = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) != 0) begin
            t = int'($urandom_range(0, 2));
            set_issue(t, int'($urandom_range(0, 31)), {$urandom, 2'b00},
                      1'($urandom), (t != 2) && ($urandom_range(0, 1) == 1), $urandom);
         end
         for (int k = 0; k < NUM_WB; k++)
            if ($urandom_range(0, 1) == 1) begin
               if (q.size() > 0 && $urandom_range(0, 3) != 0)
                  a = q[$urandom_range(0, q.size() - 1)].idx;
               else
                  a = int'($urandom_range(0, DEPTH - 1));
               set_wb(k, a, $urandom, 1'($urandom), $urandom);
            end
         rif.qry_idx1 = IDX_W'($urandom_range(0, DEPTH - 1));
         rif.qry_idx2 = IDX_W'($urandom_range(0, DEPTH - 1));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
